// File: rtl/demux_stream_1_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : demux_stream_1_n                                           |
// | Description : Registered 1:N stream demultiplexer. One tagged word per   |
// |               cycle is accepted on a valid/ready input and routed to     |
// |               exactly one of N destinations. The data bus is shared and  |
// |               out_valid is one-hot. A two-entry buffer (output reg plus  |
// |               skid reg) keeps in_ready a function of registered state.   |
// | Optional    : DEMUX_BCAST_EN adds in_bcast; a broadcast entry is offered |
// |               to all N destinations and retires once every one of them  |
// |               has taken it.                                              |
// | Ports       : clk, rst_n       clock, async active-low reset             |
// |               in_valid/ready   input handshake                          |
// |               in_data, in_sel  word and destination index               |
// |               in_bcast         broadcast flag (DEMUX_BCAST_EN only)     |
// |               out_valid[N]     one-hot destination valid                |
// |               out_ready[N]     per-destination ready                    |
// |               out_data,out_sel word and index in the output reg         |
// |               sel_err          pulse: out-of-range word discarded       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module demux_stream_1_n #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic             in_bcast,
`endif
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             sel_err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  // N widened by one bit so the range compare is exact even when N == 2**SEL_W.
  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
`ifdef DEMUX_BCAST_EN
  logic             out_bcast_q, out_bcast_d;
  logic             skid_bcast_q, skid_bcast_d;
  logic [N-1:0]     done_q, done_d;
`endif

  logic         occupied;
  logic         in_range;
  logic         accept;
  logic         drain;
  logic [N-1:0] hit;

  assign occupied = (occ_q != ST_EMPTY);
  assign in_range = ({1'b0, out_sel_q} < N_EXT);
  assign in_ready = (occ_q != ST_TWO);
  assign accept   = in_valid & in_ready;
  assign out_data = out_data_q;
  assign out_sel  = out_sel_q;
  assign hit      = out_valid & out_ready;

  // Destination decode, driven purely from registered state.
  always_comb begin
    out_valid = '0;
`ifdef DEMUX_BCAST_EN
    if (occupied && out_bcast_q) begin
      out_valid = ~done_q;
    end else begin
      for (int i = 0; i < N; i++) begin
        out_valid[i] = occupied && in_range && (out_sel_q == SEL_W'(i));
      end
    end
`else
    for (int i = 0; i < N; i++) begin
      out_valid[i] = occupied && in_range && (out_sel_q == SEL_W'(i));
    end
`endif
  end

  // An out-of-range word has no consumer, so it retires unconditionally in
  // the cycle it sits in the output reg; that same cycle flags sel_err.
  always_comb begin
`ifdef DEMUX_BCAST_EN
    if (out_bcast_q) begin
      drain   = occupied && (&(done_q | hit));
      sel_err = 1'b0;
    end else begin
      drain   = occupied && (!in_range || (|hit));
      sel_err = occupied && !in_range;
    end
`else
    drain   = occupied && (!in_range || (|hit));
    sel_err = occupied && !in_range;
`endif
  end

  // Occupancy and datapath next-state.
  always_comb begin
    occ_d       = occ_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
`ifdef DEMUX_BCAST_EN
    out_bcast_d  = out_bcast_q;
    skid_bcast_d = skid_bcast_q;
    // Every load into the output reg coincides with a drain (or with EMPTY,
    // where done is already clear), so clearing on drain covers "clear on load".
    done_d       = drain ? '0 : (done_q | hit);
`endif
    case (occ_q)
      ST_EMPTY: begin
        if (accept) begin
          out_data_d = in_data;
          out_sel_d  = in_sel;
`ifdef DEMUX_BCAST_EN
          out_bcast_d = in_bcast;
`endif
          occ_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (drain && accept) begin
          out_data_d = in_data;
          out_sel_d  = in_sel;
`ifdef DEMUX_BCAST_EN
          out_bcast_d = in_bcast;
`endif
        end else if (drain) begin
          occ_d = ST_EMPTY;
        end else if (accept) begin
          skid_data_d = in_data;
          skid_sel_d  = in_sel;
`ifdef DEMUX_BCAST_EN
          skid_bcast_d = in_bcast;
`endif
          occ_d       = ST_TWO;
        end
      end
      ST_TWO: begin
        if (drain) begin
          out_data_d = skid_data_q;
          out_sel_d  = skid_sel_q;
`ifdef DEMUX_BCAST_EN
          out_bcast_d = skid_bcast_q;
`endif
          occ_d      = ST_ONE;
        end
      end
      default: begin
        occ_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= ST_EMPTY;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
`ifdef DEMUX_BCAST_EN
      out_bcast_q  <= 1'b0;
      skid_bcast_q <= 1'b0;
      done_q       <= '0;
`endif
    end else begin
      occ_q       <= occ_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
`ifdef DEMUX_BCAST_EN
      out_bcast_q  <= out_bcast_d;
      skid_bcast_q <= skid_bcast_d;
      done_q       <= done_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_1_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_demux_stream_1_n                                        |
// | Description : Self-checking bench for demux_stream_1_n. One instance    |
// |               with N=8 and one with N=5 (for out-of-range words).        |
// |               Broadcast sequence only when DEMUX_BCAST_EN is defined.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_demux_stream_1_n;

  logic clk;
  logic rst_n;

  // N = 8 instance
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_sel;
  logic        sel_err;

  // N = 5 instance
  logic        in_valid5;
  logic        in_ready5;
  logic [31:0] in_data5;
  logic [2:0]  in_sel5;
  logic [4:0]  out_valid5;
  logic [4:0]  out_ready5;
  logic [31:0] out_data5;
  logic [2:0]  out_sel5;
  logic        sel_err5;

`ifdef DEMUX_BCAST_EN
  logic        in_bcast;
  logic        in_bcast5;
`endif

  int n_cmp;
  int n_fail;

  demux_stream_1_n #(.WIDTH(32), .SEL_W(3), .N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .sel_err   (sel_err)
  );

  demux_stream_1_n #(.WIDTH(32), .SEL_W(3), .N(5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .in_data   (in_data5),
    .in_sel    (in_sel5),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (in_bcast5),
`endif
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_data  (out_data5),
    .out_sel   (out_sel5),
    .sel_err   (sel_err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [2:0]  sel;
    logic [31:0] data;
    logic [7:0]  rdy;
    logic        e_ir;
    logic [7:0]  e_ov;
    logic [31:0] e_data;
    logic [2:0]  e_sel;
    logic        e_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //          vld  sel   data          rdy     ir    ov      e_data        e_sel e_err
    vecs[0]  = '{1'b1, 3'd3, 32'hA5A5A5A5, 8'h00, 1'b1, 8'h08, 32'hA5A5A5A5, 3'd3, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 32'h00000000, 8'h08, 1'b1, 8'h00, 32'hA5A5A5A5, 3'd3, 1'b0};
    vecs[2]  = '{1'b1, 3'd1, 32'h11111111, 8'h00, 1'b1, 8'h02, 32'h11111111, 3'd1, 1'b0};
    vecs[3]  = '{1'b1, 3'd2, 32'h22222222, 8'h00, 1'b0, 8'h02, 32'h11111111, 3'd1, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 32'h00000000, 8'h04, 1'b0, 8'h02, 32'h11111111, 3'd1, 1'b0};
    vecs[5]  = '{1'b1, 3'd5, 32'h55555555, 8'h04, 1'b0, 8'h02, 32'h11111111, 3'd1, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 32'h00000000, 8'h02, 1'b1, 8'h04, 32'h22222222, 3'd2, 1'b0};
    vecs[7]  = '{1'b1, 3'd7, 32'h77777777, 8'h04, 1'b1, 8'h80, 32'h77777777, 3'd7, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 32'h00000000, 8'hFF, 1'b1, 8'h00, 32'h77777777, 3'd7, 1'b0};
    vecs[9]  = '{1'b1, 3'd0, 32'h0F0F0F0F, 8'hFF, 1'b1, 8'h01, 32'h0F0F0F0F, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 32'h00000000, 8'hFE, 1'b1, 8'h01, 32'h0F0F0F0F, 3'd0, 1'b0};
    vecs[11] = '{1'b0, 3'd0, 32'h00000000, 8'h01, 1'b1, 8'h00, 32'h0F0F0F0F, 3'd0, 1'b0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sel     = '0;
    out_ready  = '0;
    in_valid5  = 1'b0;
    in_data5   = '0;
    in_sel5    = '0;
    out_ready5 = '0;
`ifdef DEMUX_BCAST_EN
    in_bcast   = 1'b0;
    in_bcast5  = 1'b0;
`endif

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_sel",   32'(out_sel),   32'd0);
    check("rst_sel_err",   32'(sel_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: latency, back-pressure, drain/accept combinations
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      in_valid  = vecs[v].vld;
      in_sel    = vecs[v].sel;
      in_data   = vecs[v].data;
      out_ready = vecs[v].rdy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_in_ready", v),  32'(in_ready),  32'(vecs[v].e_ir));
      check($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].e_ov));
      check($sformatf("v%0d_out_data", v),  out_data,       vecs[v].e_data);
      check($sformatf("v%0d_out_sel", v),   32'(out_sel),   32'(vecs[v].e_sel));
      check($sformatf("v%0d_sel_err", v),   32'(sel_err),   32'(vecs[v].e_err));
    end

    // Async reset with both entries occupied
    @(negedge clk);
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_sel    = 3'd4;
    in_data   = 32'h44444444;
    @(negedge clk);
    in_sel    = 3'd6;
    in_data   = 32'h66666666;
    @(posedge clk);
    #1;
    check("two_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_sel_err",   32'(sel_err),   32'd0);
    check("arst_out_data",  out_data,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Throughput: 16 back-to-back words, all destinations ready
    out_ready = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("tp%0d_in_ready", i), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_sel   = 3'(i % 8);
      in_data  = 32'hC0000000 + 32'(i);
      @(posedge clk);
      #1;
      check($sformatf("tp%0d_out_valid", i), 32'(out_valid), 32'(8'h01 << (i % 8)));
      check($sformatf("tp%0d_out_data", i),  out_data,       32'hC0000000 + 32'(i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("tp_end_out_valid", 32'(out_valid), 32'd0);

    // Out-of-range words on the N=5 instance
    @(negedge clk);
    out_ready5 = 5'h1F;
    in_valid5  = 1'b1;
    in_sel5    = 3'd6;
    in_data5   = 32'h66666666;
    @(posedge clk);
    #1;
    check("rng6_out_valid", 32'(out_valid5), 32'd0);
    check("rng6_sel_err",   32'(sel_err5),   32'd1);
    check("rng6_in_ready",  32'(in_ready5),  32'd1);
    @(negedge clk);
    in_sel5  = 3'd0;
    in_data5 = 32'h00001234;
    @(posedge clk);
    #1;
    check("rng0_out_valid", 32'(out_valid5), 32'h01);
    check("rng0_sel_err",   32'(sel_err5),   32'd0);
    check("rng0_out_data",  out_data5,       32'h00001234);
    @(negedge clk);
    in_valid5 = 1'b0;
    @(posedge clk);
    #1;
    check("rng0_drained", 32'(out_valid5), 32'd0);
    check("rng_idle_err", 32'(sel_err5),   32'd0);
    // sel == N is out of range and retires even with no ready asserted
    @(negedge clk);
    out_ready5 = 5'h00;
    in_valid5  = 1'b1;
    in_sel5    = 3'd5;
    in_data5   = 32'h55555555;
    @(posedge clk);
    #1;
    check("rng5_sel_err",   32'(sel_err5),   32'd1);
    check("rng5_out_valid", 32'(out_valid5), 32'd0);
    @(negedge clk);
    in_valid5 = 1'b0;
    @(posedge clk);
    #1;
    check("rng5_after_err", 32'(sel_err5),   32'd0);
    check("rng5_in_ready",  32'(in_ready5),  32'd1);
    check("rng5_after_ov",  32'(out_valid5), 32'd0);

`ifdef DEMUX_BCAST_EN
    // Broadcast with staggered readies
    @(negedge clk);
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_bcast  = 1'b1;
    in_sel    = 3'd6;
    in_data   = 32'hBBBBBBBB;
    @(posedge clk);
    #1;
    check("bc_load_out_valid", 32'(out_valid), 32'hFF);
    check("bc_load_sel_err",   32'(sel_err),   32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_bcast = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_ready = 8'(8'h01 << i);
      if (i == 7) begin
        in_valid = 1'b1;
        in_bcast = 1'b0;
        in_sel   = 3'd2;
        in_data  = 32'h2B2B2B2B;
      end
      @(posedge clk);
      #1;
      if (i < 7) begin
        check($sformatf("bc%0d_out_valid", i), 32'(out_valid), 32'(8'hFF & ~8'((16'h0002 << i) - 16'd1)));
        check($sformatf("bc%0d_out_data", i),  out_data,       32'hBBBBBBBB);
      end else begin
        check("bc_next_out_valid", 32'(out_valid), 32'h04);
        check("bc_next_out_data",  out_data,       32'h2B2B2B2B);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 8'hFF;
    @(posedge clk);
    #1;
    check("bc_end_out_valid", 32'(out_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
